dmem_arbiter: RTL
=================

# dmem_arbiter

Shared data-memory responder for the multicore matrix-multiply build. It is the slave end of the core data-memory interface that each `core` drives (read/write strobes, 16-bit address, 16-bit write data). It arbitrates up to `NCORES` cores round-robin onto one internal single-port 16-bit RAM. It returns a one-cycle acknowledge with read data, so cores can share one data memory without collisions.

## Interface
- `NCORES`, 4: number of requesting cores (2..8).
- `DEPTH`, 256: RAM words; power of two.
- `AW`, 8: log2(`DEPTH`); address bits actually used.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `read_MD`  in  `NCORES`  per-core read request, bit k = core k.
- `write_MD`  in  `NCORES`  per-core write request.
- `addr`  in  16*`NCORES`  per-core address, core k at [16k+15:16k].
- `wdata`  in  16*`NCORES`  per-core write data, same packing.
- `ack`  out  `NCORES`  one-cycle completion pulse, bit k = core k.
- `rdata`  out  16*`NCORES`  per-core registered read data, same packing.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  3  index of the core being served; valid while `busy`.
- `err`  out  1  sticky; set when any core asserts `read_MD` and `write_MD` together.

## Operation
- Request rule: a core raises exactly one of `read_MD[k]`/`write_MD[k]` and holds `addr`/`wdata` stable until it sees `ack[k]`. It drops the request at the same edge that samples `ack[k]`=1.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any `read_MD|write_MD` bit is set, pick the winner. Latch the winner's op, `addr[AW-1:0]` and `wdata`, set `grant_id`, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: on a write, RAM[addr] <= wdata. On a read, `rdata[winner]` <= RAM[addr]. Then go to RESP.
  - RESP: `ack[winner]`=1 for this cycle only. Set the priority pointer to the winner, then go to IDLE.
- Round-robin: the search starts at pointer+1 and wraps modulo `NCORES`. The first requesting core wins. After reset the pointer is `NCORES`-1, so core 0 has first priority.
- Address: bits [15:AW] are ignored, so the address wraps modulo `DEPTH`.
- Read and write asserted together by one core: treat the request as a write and set `err`. `err` clears only on reset.
- `rdata[k]` keeps its last value until core k's next read completes. Writes never change any `rdata`.
- A write followed by a read of the same address, from any cores, returns the new value.
- Requests that are not granted are held off with no side effects. There is no starvation: with all cores requesting continuously, each core is served once every `NCORES` grants.

## Timing
- Reset (async assert, sync release) sets:
  - FSM to IDLE; `ack`, `busy`, `err` = 0.
  - `grant_id` = 0; `rdata` = 0; pointer = `NCORES`-1.
  - RAM contents are not cleared (undefined at power-up).
- Latency: a request visible in IDLE cycle t produces `ack` in cycle t+2. Read data is valid in `rdata` in that same cycle t+2.
- Throughput: one access per 3 cycles. IDLE is re-entered at t+3, and a pending request from another core is granted in that cycle.
- `busy`=1 in cycles t+1 and t+2 only.
- Requests arriving while `busy` are not sampled until the next IDLE.
- Reset asserted in ACCESS: whether the in-flight write is committed is undefined. `ack` is never issued for the aborted access.
- Reset asserted in RESP: `ack` drops immediately, because reset is asynchronous.

## Test plan
- Reset, then core 0 writes 0x1234 to addr 0x0005, then reads 0x0005 → `ack[0]` pulses 2 cycles after each request; `rdata[0]`=0x1234; `busy` high for exactly 2 cycles per access.
- Cores 0–3 each request a write in the same cycle, each with its own address and data 0xA0+k → grant order 0,1,2,3; acks 3 cycles apart; read-back of each address returns its data.
- All four cores request reads continuously for 12 grants → each core is acked exactly 3 times; the grant sequence cycles 0,1,2,3.
- Core 1 reads addr 0x0105 after 0xBEEF is written to 0x0005 (`DEPTH`=256) → `rdata[1]`=0xBEEF (address wraps).
- Core 2 asserts `read_MD` and `write_MD` with data 0x00FF at addr 0x10 → treated as a write; `err`=1 and stays 1; a later read of 0x10 returns 0x00FF.
- Pull `RESET_N` low in the RESP cycle of a core 3 read → `ack` drops immediately. After release: `busy`=0, `err`=0, `rdata`=0, and the next simultaneous requests from cores 0 and 3 grant core 0 first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Core-to-data-memory bus: per-core read/write strobes, address and write data,
// with per-core acknowledge and registered read data returned by the arbiter.
interface dmem_arbiter_if #(
    parameter int NCORES = 4
);
    logic [NCORES-1:0]    read_MD;
    logic [NCORES-1:0]    write_MD;
    logic [16*NCORES-1:0] addr;
    logic [16*NCORES-1:0] wdata;
    logic [NCORES-1:0]    ack;
    logic [16*NCORES-1:0] rdata;

    modport master (
        output read_MD, write_MD, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  read_MD, write_MD, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port 16-bit RAM among NCORES cores.
// Each access takes IDLE -> ACCESS -> RESP, with a one-cycle ack in RESP.
module dmem_arbiter #(
    parameter int NCORES = 4,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                clk,
    input  logic                RESET_N,
    dmem_arbiter_if.slave       bus,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic                err
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_ptr;
    logic [2:0]        r_grant;
    logic              r_is_wr;
    logic [AW-1:0]     r_addr;
    logic [15:0]       r_wdata;
    logic              r_err;
    logic [15:0]       r_rdata [NCORES];
    logic [15:0]       r_mem [DEPTH];
    logic [15:0]       r_mem_q;

    logic [NCORES-1:0] w_req;
    logic              w_found;
    logic [2:0]        w_win;
    logic              w_win_wr;
    logic [AW-1:0]     w_win_addr;
    logic [15:0]       w_win_wdata;

    // Two passes give the rotated search: cores above the pointer first, then wrap.
    always_comb begin
        w_req       = bus.read_MD | bus.write_MD;
        w_found     = 1'b0;
        w_win       = r_ptr;
        w_win_wr    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (!w_found && w_req[k] && (k > int'(r_ptr))) begin
                w_found     = 1'b1;
                w_win       = 3'(k);
                w_win_wr    = bus.write_MD[k];
                w_win_addr  = bus.addr[16*k +: AW];
                w_win_wdata = bus.wdata[16*k +: 16];
            end
        end
        for (int k = 0; k < NCORES; k++) begin
            if (!w_found && w_req[k]) begin
                w_found     = 1'b1;
                w_win       = 3'(k);
                w_win_wr    = bus.write_MD[k];
                w_win_addr  = bus.addr[16*k +: AW];
                w_win_wdata = bus.wdata[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ptr   <= 3'(NCORES - 1);
            r_grant <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < NCORES; k++) begin
                r_rdata[k] <= '0;
            end
        end else begin
            if (|(bus.read_MD & bus.write_MD)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_is_wr <= w_win_wr;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                    end
                end
                S_ACCESS: begin
                    for (int k = 0; k < NCORES; k++) begin
                        if (!r_is_wr && (r_grant == 3'(k))) begin
                            r_rdata[k] <= r_mem_q;
                        end
                    end
                end
                S_RESP:  r_ptr <= r_grant;
                default: ;
            endcase
        end
    end

    // RAM is read one cycle early (at the grant edge) so the read stays registered;
    // the only write happens in ACCESS, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_is_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
        if (r_state == S_IDLE) begin
            r_mem_q <= r_mem[w_win_addr];
        end
    end

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            assign bus.ack[gi]             = (r_state == S_RESP) && (r_grant == 3'(gi));
            assign bus.rdata[16*gi +: 16]  = r_rdata[gi];
        end
    endgenerate

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;
    assign err      = r_err;
endmodule
